// File: rtl/aes_cmd_sequencer_pkg.sv
// Shared definitions for the AES command sequencer: engine command codes,
// sequencer state encodings and default frame geometry.
package aes_cmd_sequencer_pkg;

  localparam logic [1:0] C_ID = 2'b00;
  localparam logic [1:0] C_SP = 2'b01;
  localparam logic [1:0] C_SK = 2'b10;
  localparam logic [1:0] C_ST = 2'b11;

  localparam int N_PT_DEF          = 16;
  localparam int N_KEY_DEF         = 16;
  localparam int START_TIMEOUT_DEF = 64;

  typedef enum logic [3:0] {
    S_COLLECT,
    S_WAIT_RDY,
    S_LOAD_PT,
    S_GAP1,
    S_LOAD_KEY,
    S_GAP2,
    S_START,
    S_FIN_OK,
    S_FIN_TO
  } seq_state_t;

endpackage

// File: rtl/aes_cmd_sequencer_frame_buffer.sv
// Frame register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes are accepted whenever we is high.
module aes_cmd_sequencer_frame_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // No reset: contents are only read after a full frame has been written.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Buffers a 32-byte PT+key frame from a valid/ready byte stream and replays it as SP/ID/SK/ID/ST.
// Latency: last byte accepted -> first SP 2 cycles (interface_ready high); first SP -> ST 34 cycles.
// Backpressure: s_ready high only while collecting; the engine side has no backpressure after WAIT_RDY.
module aes_cmd_sequencer
  import aes_cmd_sequencer_pkg::*;
#(
  parameter int N_PT          = N_PT_DEF,
  parameter int N_KEY         = N_KEY_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [1:0] cmd,
  output logic [7:0] din,
  input  logic       interface_ready,
  input  logic       engine_done,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int FRAME = N_PT + N_KEY;
  localparam int PTR_W = $clog2(FRAME);
  localparam int TC_W  = $clog2(START_TIMEOUT + 1);

  seq_state_t       state, state_nxt;
  logic [PTR_W-1:0] wptr, wptr_nxt, rptr, rptr_nxt;
  logic [TC_W-1:0]  tcnt, tcnt_nxt;
  logic             wr_en;
  logic [7:0]       rd_dat;
  logic [1:0]       cmd_nxt;
  logic [7:0]       din_nxt;
  logic             s_ready_nxt, busy_nxt, done_nxt, timeout_nxt;

  aes_cmd_sequencer_frame_buffer #(.DEPTH(FRAME)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (s_data),
    .raddr (rptr_nxt),
    .rdata (rd_dat)
  );

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state   <= S_COLLECT;
      wptr    <= '0;
      rptr    <= '0;
      tcnt    <= '0;
      cmd     <= C_ID;
      din     <= 8'h00;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      tcnt    <= tcnt_nxt;
      cmd     <= cmd_nxt;
      din     <= din_nxt;
      s_ready <= s_ready_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wptr_nxt    = wptr;
    rptr_nxt    = rptr;
    tcnt_nxt    = tcnt;
    wr_en       = 1'b0;
    cmd_nxt     = C_ID;
    din_nxt     = 8'h00;
    s_ready_nxt = 1'b0;
    busy_nxt    = 1'b1;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;

    case (state)
      S_COLLECT: begin
        if (s_valid && s_ready) begin
          wr_en = 1'b1;
          if (wptr == PTR_W'(FRAME - 1)) state_nxt = S_WAIT_RDY;
          else                           wptr_nxt  = wptr + PTR_W'(1);
        end
      end
      S_WAIT_RDY: begin
        if (interface_ready) begin
          state_nxt = S_LOAD_PT;
          rptr_nxt  = '0;
        end
      end
      S_LOAD_PT: begin
        if (rptr == PTR_W'(N_PT - 1)) state_nxt = S_GAP1;
        else                          rptr_nxt  = rptr + PTR_W'(1);
      end
      S_GAP1: begin
        state_nxt = S_LOAD_KEY;
        rptr_nxt  = PTR_W'(N_PT);
      end
      S_LOAD_KEY: begin
        if (rptr == PTR_W'(FRAME - 1)) state_nxt = S_GAP2;
        else                           rptr_nxt  = rptr + PTR_W'(1);
      end
      S_GAP2: begin
        state_nxt = S_START;
        tcnt_nxt  = '0;
      end
      S_START: begin
        if (tcnt != '1) tcnt_nxt = tcnt + TC_W'(1);
        // tcnt==0 is the first START cycle: a done left over from the previous frame is ignored.
        if (engine_done && (tcnt != '0))            state_nxt = S_FIN_OK;
        else if (tcnt == TC_W'(START_TIMEOUT - 1))  state_nxt = S_FIN_TO;
      end
      S_FIN_OK, S_FIN_TO: begin
        state_nxt = S_COLLECT;
        wptr_nxt  = '0;
      end
      default: state_nxt = S_COLLECT;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_nxt)
      S_COLLECT: begin
        busy_nxt    = 1'b0;
        s_ready_nxt = 1'b1;
      end
      S_LOAD_PT: begin
        cmd_nxt = C_SP;
        din_nxt = rd_dat;
      end
      S_LOAD_KEY: begin
        cmd_nxt = C_SK;
        din_nxt = rd_dat;
      end
      S_START:  cmd_nxt = C_ST;
      S_FIN_OK: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      S_FIN_TO: begin
        busy_nxt    = 1'b0;
        timeout_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: frame collection, replay order, done/timeout
// handling, interface_ready stalls and mid-load reset.
module tb_aes_cmd_sequencer;
  import aes_cmd_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       interface_ready;
  logic       engine_done;
  logic       busy;
  logic       done;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int nwr;
  int nst;
  logic [7:0] fa [32];
  logic [7:0] fb [32];

  aes_cmd_sequencer dut (
    .clk             (clk),
    .rst_            (rst_),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .cmd             (cmd),
    .din             (din),
    .interface_ready (interface_ready),
    .engine_done     (engine_done),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams one frame; returns after the edge that accepted the last byte.
  task automatic send_frame(input logic [7:0] f [32], input bit toggle, output int writes);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    writes = 0;
    s_valid = 1'b1;
    s_data = f[0];
    while (i < 32 && guard < 200) begin
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        i++;
        writes++;
      end
      if (toggle) s_valid = ~s_valid;
      if (i < 32) s_data = f[i];
    end
    s_valid = 1'b0;
  endtask

  // Checks SP burst, gap, SK burst, gap, first ST; returns at the first START cycle.
  task automatic replay(input logic [7:0] f [32], input string tag);
    int g;
    g = 0;
    while (cmd !== C_SP && g < 80) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_sp_found"}, 32'(cmd), 32'(C_SP));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_pt%0d", tag, k), {cmd, din}, {C_SP, f[k]});
      @(negedge clk);
    end
    chk({tag, "_gap1"}, {cmd, din, busy}, {C_ID, 8'h00, 1'b1});
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_key%0d", tag, k), {cmd, din}, {C_SK, f[16+k]});
      @(negedge clk);
    end
    chk({tag, "_gap2"}, {cmd, din, busy}, {C_ID, 8'h00, 1'b1});
    @(negedge clk);
    chk({tag, "_st_first"}, {cmd, din, busy}, {C_ST, 8'h00, 1'b1});
  endtask

  // From the first START cycle: raise engine_done in START cycle n (or from cycle 1 if stale).
  task automatic finish_done(input int n, input bit stale, input string tag);
    if (stale) engine_done = 1'b1;
    repeat (n - 1) @(posedge clk);
    #1 engine_done = 1'b1;
    @(negedge clk);
    chk({tag, "_st_before_done"}, 32'(cmd), 32'(C_ST));
    @(posedge clk);
    #1 engine_done = 1'b0;
    @(negedge clk);
    chk({tag, "_fin_ok"}, {cmd, busy, done, timeout}, {C_ID, 3'b010});
    @(negedge clk);
    chk({tag, "_collect"}, {cmd, busy, done, timeout, s_ready}, {C_ID, 4'b0001});
  endtask

  initial begin
    fa = '{8'h00, 8'h04, 8'h12, 8'h14, 8'h12, 8'h04, 8'h12, 8'h00,
           8'h0C, 8'h00, 8'h13, 8'h11, 8'h08, 8'h23, 8'h19, 8'h19,
           8'h24, 8'h75, 8'hA2, 8'hB3, 8'h34, 8'h75, 8'h56, 8'h88,
           8'h31, 8'hE2, 8'h12, 8'h00, 8'h13, 8'hAA, 8'h54, 8'h87};
    for (int i = 0; i < 32; i++) fb[i] = 8'(8'hFF - 3 * i);

    rst_ = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    interface_ready = 1'b1;
    engine_done = 1'b0;

    // Reset state and s_ready rising one edge after release
    repeat (2) @(negedge clk);
    chk("rst_outs", {cmd, din, s_ready, busy, done, timeout}, 32'h0);
    @(posedge clk);
    #1 rst_ = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", 32'(s_ready), 32'h0);
    @(negedge clk);
    chk("rdy_after_edge", {s_ready, busy}, 2'b10);

    // Scenarios 1+2: frame A, 2-cycle latency, done on 9th START cycle
    send_frame(fa, 1'b0, nwr);
    chk("s1_writes", nwr, 32);
    @(negedge clk);
    chk("s1_wait_rdy", {cmd, busy, s_ready}, {C_ID, 2'b10});
    @(negedge clk);
    chk("s1_latency_sp", {cmd, din}, {C_SP, fa[0]});
    replay(fa, "s1");
    finish_done(9, 1'b0, "s2");

    // Scenario 3: engine_done held low -> 64 ST cycles then timeout pulse
    send_frame(fa, 1'b0, nwr);
    replay(fa, "s3");
    nst = 1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (cmd === C_ST) nst++;
      else break;
    end
    chk("s3_st_len", nst, 64);
    chk("s3_fin_to", {cmd, busy, done, timeout}, {C_ID, 3'b001});
    @(negedge clk);
    chk("s3_collect", {cmd, busy, done, timeout, s_ready}, {C_ID, 4'b0001});

    // Scenario 4: s_valid toggling; done coincides with the timeout limit (done wins)
    send_frame(fa, 1'b1, nwr);
    chk("s4_writes", nwr, 32);
    replay(fa, "s4");
    finish_done(64, 1'b0, "s4");

    // Scenario 5: interface_ready low for 10 cycles; stale done in first START cycle
    interface_ready = 1'b0;
    send_frame(fa, 1'b0, nwr);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("s5_stall%0d", k), {cmd, busy, s_ready}, {C_ID, 2'b10});
    end
    @(posedge clk);
    #1 interface_ready = 1'b1;
    @(negedge clk);
    chk("s5_rdy_rise", {cmd, busy}, {C_ID, 1'b1});
    @(posedge clk);
    #1 interface_ready = 1'b0;
    @(negedge clk);
    chk("s5_first_sp", {cmd, din}, {C_SP, fa[0]});
    replay(fa, "s5");
    finish_done(2, 1'b1, "s5");

    // Scenario 6: reset during 5th LOAD_KEY cycle, then a fresh frame
    interface_ready = 1'b1;
    send_frame(fa, 1'b0, nwr);
    for (int g = 0; g < 80 && cmd !== C_SK; g++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("s6_key5", {cmd, din}, {C_SK, fa[20]});
    #2 rst_ = 1'b1;
    #1;
    chk("s6_async_rst", {cmd, din, busy, s_ready}, {C_ID, 8'h00, 2'b00});
    @(posedge clk);
    #1 rst_ = 1'b0;
    @(negedge clk);
    chk("s6_rdy_low", 32'(s_ready), 32'h0);
    @(negedge clk);
    chk("s6_rdy_high", 32'(s_ready), 32'h1);
    send_frame(fb, 1'b0, nwr);
    chk("s6_writes", nwr, 32);
    replay(fb, "s6");
    finish_done(3, 1'b0, "s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
